// File: rtl/bomb_pkg.sv
// Shared defaults, width helpers, cell indexing and win encoding for the bomb field.
package bomb_pkg;

   localparam int unsigned DEF_GRID_W      = 10;
   localparam int unsigned DEF_GRID_H      = 10;
   localparam int unsigned DEF_NUM_PLAYERS = 2;
   localparam int unsigned DEF_FUSE        = 3;
   localparam int unsigned DEF_RADIUS      = 2;
   localparam int unsigned DEF_HP_INIT     = 3;

   localparam int unsigned WINNER_NONE     = 0;

   typedef enum logic {
      GS_PLAY = 1'b0,
      GS_OVER = 1'b1
   } game_state_t;

   function automatic int unsigned cw_of(input int unsigned w, input int unsigned h);
      int unsigned m;
      m = (w > h) ? w : h;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic int unsigned hpw_of(input int unsigned hp);
      return (hp > 0) ? $clog2(hp + 1) : 1;
   endfunction

   function automatic int unsigned cell_idx(input int unsigned x, input int unsigned y,
                                            input int unsigned h);
      return x * h + y;
   endfunction

endpackage

// File: rtl/bomb_field_cell.sv
// Per-cell fuse counter: arms on placement, fires on its last tick or when caught in flame.
module bomb_cell
   import bomb_pkg::*;
#(
   parameter int unsigned FUSE = DEF_FUSE
) (
   input  logic bombClk,
   input  logic rst,
   input  logic i_hold,
   input  logic i_place,
   input  logic i_detonate,
   output logic o_armed,
   output logic o_fires
);

   localparam int unsigned FW = $clog2(FUSE + 1);

   logic [FW-1:0] r_fuse;

   assign o_armed = (r_fuse != '0);
   assign o_fires = (r_fuse == FW'(1)) || (o_armed && i_detonate);

   always_ff @(posedge bombClk) begin
      if (rst) begin
         r_fuse <= '0;
      end else if (!i_hold) begin
         if (o_fires)
            r_fuse <= '0;
         else if (o_armed)
            r_fuse <= r_fuse - FW'(1);
         else if (i_place)
            r_fuse <= FW'(FUSE);
      end
   end

endmodule

// File: rtl/bomb_field.sv
// Bomb-field engine: per-cell fuses, wall-clipped cross blasts with chaining,
// player damage, placement arbitration and sticky win detection.
module bomb_field
   import bomb_pkg::*;
#(
   parameter  int unsigned GRID_W      = DEF_GRID_W,
   parameter  int unsigned GRID_H      = DEF_GRID_H,
   parameter  int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
   parameter  int unsigned FUSE        = DEF_FUSE,
   parameter  int unsigned RADIUS      = DEF_RADIUS,
   parameter  int unsigned HP_INIT     = DEF_HP_INIT,
   localparam int unsigned CW          = cw_of(GRID_W, GRID_H),
   localparam int unsigned HP_W        = hpw_of(HP_INIT),
   localparam int unsigned WNW         = $clog2(NUM_PLAYERS + 1),
   localparam int unsigned NC          = GRID_W * GRID_H
) (
   input  logic                        bombClk,
   input  logic                        rst,
   input  logic [NC-1:0]               i_wall_map,
   input  logic [NUM_PLAYERS-1:0]      i_place_v,
   input  logic [NUM_PLAYERS*CW-1:0]   i_place_x,
   input  logic [NUM_PLAYERS*CW-1:0]   i_place_y,
   input  logic [NUM_PLAYERS*CW-1:0]   i_player_x,
   input  logic [NUM_PLAYERS*CW-1:0]   i_player_y,
   output logic [NC-1:0]               o_bomb_map,
   output logic [NC-1:0]               o_flame_map,
   output logic [NUM_PLAYERS*HP_W-1:0] o_health,
   output logic [NUM_PLAYERS-1:0]      o_alive,
   output logic                        o_game_over,
   output logic [WNW-1:0]              o_winner
);

   localparam int unsigned CIW = (NC > 1) ? $clog2(NC) : 1;

   game_state_t                            r_state;
   logic [NC-1:0]                          r_flame;
   logic [NUM_PLAYERS-1:0][HP_W-1:0]       r_health;
   logic [NUM_PLAYERS-1:0]                 r_alive;
   logic [WNW-1:0]                         r_winner;

   logic                                   w_hold;
   logic [NC-1:0]                          w_place;
   logic [NC-1:0]                          w_armed;
   logic [NC-1:0]                          w_det;
   logic [NC-1:0]                          w_blast;
   logic [NUM_PLAYERS-1:0][HP_W-1:0]       w_hp_next;
   logic [NUM_PLAYERS-1:0]                 w_alive_next;
   int unsigned                            w_alive_cnt;
   int unsigned                            w_last;

   assign w_hold      = (r_state == GS_OVER);
   assign o_bomb_map  = w_armed;
   assign o_flame_map = r_flame;
   assign o_health    = r_health;
   assign o_alive     = r_alive;
   assign o_game_over = (r_state == GS_OVER);
   assign o_winner    = r_winner;

   for (genvar c = 0; c < NC; c++) begin : g_cell
      bomb_cell #(.FUSE(FUSE)) u_cell (
         .bombClk    (bombClk),
         .rst        (rst),
         .i_hold     (w_hold),
         .i_place    (w_place[c]),
         .i_detonate (r_flame[c]),
         .o_armed    (w_armed[c]),
         .o_fires    (w_det[c])
      );
   end

   // Each ray walks outward from a detonating cell and stops at a wall or the grid edge.
   always_comb begin
      int nx, ny, sx, sy;
      logic open;
      nx = 0; ny = 0; sx = 0; sy = 0; open = 1'b0;
      w_blast = w_det;
      for (int unsigned x = 0; x < GRID_W; x++) begin
         for (int unsigned y = 0; y < GRID_H; y++) begin
            if (w_det[CIW'(cell_idx(x, y, GRID_H))]) begin
               for (int unsigned dir = 0; dir < 4; dir++) begin
                  sx   = (dir == 0) ? 1 : (dir == 1) ? -1 : 0;
                  sy   = (dir == 2) ? 1 : (dir == 3) ? -1 : 0;
                  nx   = int'(x);
                  ny   = int'(y);
                  open = 1'b1;
                  for (int unsigned d = 1; d <= RADIUS; d++) begin
                     nx = nx + sx;
                     ny = ny + sy;
                     if (open) begin
                        if (nx < 0 || nx >= int'(GRID_W) || ny < 0 || ny >= int'(GRID_H))
                           open = 1'b0;
                        else if (i_wall_map[CIW'(nx * int'(GRID_H) + ny)])
                           open = 1'b0;
                        else
                           w_blast[CIW'(nx * int'(GRID_H) + ny)] = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // Players are scanned in index order, so a lower index claims a contested cell first.
   always_comb begin
      int unsigned px, py;
      logic [CIW-1:0] pc;
      px = 0; py = 0; pc = '0;
      w_place = '0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
         px = int'(i_place_x[p*CW +: CW]);
         py = int'(i_place_y[p*CW +: CW]);
         if (i_place_v[p] && r_health[p] != '0 && px < GRID_W && py < GRID_H) begin
            pc = CIW'(cell_idx(px, py, GRID_H));
            if (!i_wall_map[pc] && !w_armed[pc] && !w_blast[pc] && !w_place[pc])
               w_place[pc] = 1'b1;
         end
      end
   end

   always_comb begin
      int unsigned qx, qy;
      logic hit;
      qx = 0; qy = 0; hit = 1'b0;
      w_hp_next    = r_health;
      w_alive_next = '0;
      w_alive_cnt  = 0;
      w_last       = 0;
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
         qx  = int'(i_player_x[p*CW +: CW]);
         qy  = int'(i_player_y[p*CW +: CW]);
         hit = (qx < GRID_W && qy < GRID_H) && w_blast[CIW'(cell_idx(qx, qy, GRID_H))];
         if (hit && r_health[p] != '0)
            w_hp_next[p] = r_health[p] - HP_W'(1);
         if (w_hp_next[p] != '0) begin
            w_alive_next[p] = 1'b1;
            w_alive_cnt     = w_alive_cnt + 1;
            w_last          = p + 1;
         end
      end
   end

   always_ff @(posedge bombClk) begin
      if (rst) begin
         r_state  <= GS_PLAY;
         r_flame  <= '0;
         r_health <= {NUM_PLAYERS{HP_W'(HP_INIT)}};
         r_alive  <= '1;
         r_winner <= WNW'(WINNER_NONE);
      end else if (r_state == GS_PLAY) begin
         r_flame  <= w_blast;
         r_health <= w_hp_next;
         r_alive  <= w_alive_next;
         if (w_alive_cnt <= 1) begin
            r_state  <= GS_OVER;
            r_winner <= (w_alive_cnt == 1) ? WNW'(w_last) : WNW'(WINNER_NONE);
         end
      end
   end

endmodule
